// File: rtl/pipe_en_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_en_reg_pkg
// Shared definitions for the enabled register pipeline:
//   DEF_WIDTH / DEF_DEPTH : default data width and stage count
//   occ_width()           : width of the occupancy count, clog2(depth+1)
//   stage_t               : one pipeline stage {valid, data} at default width
// -----------------------------------------------------------------------------
package pipe_en_reg_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 3;

   // Enough bits to count 0..depth valid stages.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   typedef struct packed {
      logic                 v;
      logic [DEF_WIDTH-1:0] d;
   } stage_t;

endpackage

// File: rtl/pipe_en_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_en_reg_if
// Valid/ready word stream used on both sides of the pipeline.
//   valid : producer has a word
//   data  : the word (WIDTH bits)
//   ready : consumer accepts the word this cycle
// Modports: master drives valid/data, slave drives ready.
// -----------------------------------------------------------------------------
interface pipe_en_reg_if
   import pipe_en_reg_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic             valid;
   logic [WIDTH-1:0] data;
   logic             ready;

   modport master (output valid, output data, input  ready);
   modport slave  (input  valid, input  data, output ready);

endinterface

// File: rtl/pipe_en_reg_stage.sv
// -----------------------------------------------------------------------------
// pipe_en_reg_stage
// One valid/data flop pair of the pipeline.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   i_load       : take i_v (and i_d when i_v=1) this edge
//   i_clr        : clear the valid bit this edge, data held (wins over i_load)
//   i_v, i_d     : source stage valid/data
//   o_v, o_d     : this stage's valid/data
// -----------------------------------------------------------------------------
module pipe_en_reg_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic             i_clr,
   input  logic             i_v,
   input  logic [WIDTH-1:0] i_d,
   output logic             o_v,
   output logic [WIDTH-1:0] o_d
);

   logic             r_v;
   logic [WIDTH-1:0] r_d;

   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples its neighbour's pre-edge value; blocking here would let a word
   // ripple through several stages in one clock.
   // NOTE: the data flop is reset as well as the valid bit, because out_data
   // must read zero during reset rather than whatever was in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_v <= 1'b0;
         r_d <= '0;
      end else if (i_clr) begin
         r_v <= 1'b0;
      end else if (i_load) begin
         r_v <= i_v;
         // Bubbles move the valid bit only; data keeps its last real word.
         if (i_v) r_d <= i_d;
      end
   end

   assign o_v = r_v;
   assign o_d = r_d;

endmodule

// File: rtl/pipe_en_reg.sv
// -----------------------------------------------------------------------------
// pipe_en_reg
// DEPTH-stage enabled register pipeline with valid/ready handshake, bubble
// collapsing, backpressure and synchronous flush.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : global enable, 0 freezes all state and drops in_ready
//   flush        : with en=1, clears every valid bit on the next edge
//   s_in         : upstream stream (slave modport), in_ready driven here
//   m_out        : downstream stream (master modport), last stage
//   occ          : count of valid stages, present only when the macro
//                  PIPE_EN_REG_OCC_EN is defined
// The ready chain is combinational from m_out.ready back to s_in.ready
// through all DEPTH stages; that path is intentional.
// -----------------------------------------------------------------------------
module pipe_en_reg
   import pipe_en_reg_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               en,
   input  logic               flush,
   pipe_en_reg_if.slave       s_in,
   pipe_en_reg_if.master      m_out
`ifdef PIPE_EN_REG_OCC_EN
   ,output logic [occ_width(DEPTH)-1:0] occ
`endif
);

   logic [DEPTH-1:0] w_v;
   logic [WIDTH-1:0] w_d [DEPTH];
   logic [DEPTH:0]   w_rdy;
   logic             w_load;
   logic             w_clr;

   // A stage can advance when it is empty or the stage after it advances,
   // so an empty stage always accepts and gaps close under a stall.
   // NOTE: every signal written in always_comb gets a value before any
   // conditional logic; leaving a path unassigned would infer a latch.
   always_comb begin : rdy_chain
      logic v_acc;
      w_rdy        = '0;
      v_acc        = m_out.ready;
      w_rdy[DEPTH] = v_acc;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         v_acc    = ~w_v[i] | v_acc;
         w_rdy[i] = v_acc;
      end
   end

   assign w_load      = en & ~flush;
   assign w_clr       = en & flush;
   assign s_in.ready  = w_load & w_rdy[0];
   assign m_out.valid = w_v[DEPTH-1];
   assign m_out.data  = w_d[DEPTH-1];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             w_src_v;
      logic [WIDTH-1:0] w_src_d;

      if (gi == 0) begin : g_head
         assign w_src_v = s_in.valid;
         assign w_src_d = s_in.data;
      end else begin : g_body
         assign w_src_v = w_v[gi-1];
         assign w_src_d = w_d[gi-1];
      end

      pipe_en_reg_stage #(.WIDTH(WIDTH)) u_stage (
         .clk     (clk),
         .reset_n (reset_n),
         .i_load  (w_load & w_rdy[gi]),
         .i_clr   (w_clr),
         .i_v     (w_src_v),
         .i_d     (w_src_d),
         .o_v     (w_v[gi]),
         .o_d     (w_d[gi])
      );
   end

`ifdef PIPE_EN_REG_OCC_EN
   localparam int OCC_W = occ_width(DEPTH);

   logic [OCC_W-1:0] r_occ;
   logic             w_in_xfer;
   logic             w_out_xfer;

   assign w_in_xfer  = s_in.valid & s_in.ready;
   assign w_out_xfer = w_v[DEPTH-1] & m_out.ready & en;

   // Tracks popcount(v) incrementally; simultaneous in and out cancel.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_occ <= '0;
      end else if (w_clr) begin
         r_occ <= '0;
      end else if (w_in_xfer && !w_out_xfer) begin
         r_occ <= r_occ + OCC_W'(1);
      end else if (!w_in_xfer && w_out_xfer) begin
         r_occ <= r_occ - OCC_W'(1);
      end
   end

   assign occ = r_occ;
`endif

endmodule
